// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU op encodings, RV32I opcodes and the issue packet.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Operands are carried next to this struct because their width is a module parameter.
    typedef struct packed {
        alu_op_e    alu_ctrl;
        logic [4:0] rd;
        logic       illegal;
    } issue_pkt_t;

    function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: instruction, pc and forwarded operands into ALU operands and issue packet.
module alu_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output issue_pkt_t       pkt
);

    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             op_funct7_ok;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] shamt;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign op_funct7_ok = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    assign imm_i = WIDTH'($signed(instr[31:20]));
    assign imm_s = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_u = WIDTH'($signed({instr[31:12], 12'b0}));
    assign shamt = WIDTH'(instr[24:20]);

    always_comb begin
        op_a         = '0;
        op_b         = '0;
        pkt.alu_ctrl = ALU_ADD;
        pkt.rd       = instr[11:7];
        pkt.illegal  = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                if (op_funct7_ok) begin
                    op_a         = rs1_data;
                    op_b         = rs2_data;
                    pkt.alu_ctrl = funct3_to_op(funct3, instr[30]);
                end else begin
                    pkt.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                op_a         = rs1_data;
                op_b         = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? shamt : imm_i;
                pkt.alu_ctrl = funct3_to_op(funct3, (funct3 == 3'b101) && instr[30]);
            end
            OPC_LUI: begin
                op_b = imm_u;
            end
            OPC_AUIPC: begin
                op_a = pc;
                op_b = imm_u;
            end
            OPC_LOAD, OPC_JALR: begin
                op_a = rs1_data;
                op_b = imm_i;
            end
            OPC_STORE: begin
                op_a = rs1_data;
                op_b = imm_s;
            end
            OPC_JAL: begin
                op_a = pc;
                op_b = WIDTH'(3'd4);
            end
            OPC_BRANCH: begin
                // BEQ/BNE compare by subtraction, signed and unsigned relations by set-less-than.
                if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                    pkt.illegal = 1'b1;
                end else begin
                    op_a = rs1_data;
                    op_b = rs2_data;
                    if (!funct3[2]) begin
                        pkt.alu_ctrl = ALU_SUB;
                    end else if (!funct3[1]) begin
                        pkt.alu_ctrl = ALU_SLT;
                    end else begin
                        pkt.alu_ctrl = ALU_SLTU;
                    end
                end
            end
            default: begin
                pkt.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue register between decode and the ALU; ALU_ISSUE_SKID_EN selects a two-entry skid buffer
// with registered in_ready, otherwise a single output register with combinational in_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       rd,
    output logic             illegal
);

    logic [WIDTH-1:0] dec_op_a;
    logic [WIDTH-1:0] dec_op_b;
    issue_pkt_t       dec_pkt;

    alu_decode #(.WIDTH(WIDTH)) u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .op_a     (dec_op_a),
        .op_b     (dec_op_b),
        .pkt      (dec_pkt)
    );

    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_a_q, head_a_d;
    logic [WIDTH-1:0] head_b_q, head_b_d;
    issue_pkt_t       head_pkt_q, head_pkt_d;
    logic             push;
    logic             pop;

    assign pop = head_vld_q && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic             tail_vld_q, tail_vld_d;
    logic [WIDTH-1:0] tail_a_q, tail_a_d;
    logic [WIDTH-1:0] tail_b_q, tail_b_d;
    issue_pkt_t       tail_pkt_q, tail_pkt_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign push     = in_valid && in_ready_q;

    always_comb begin
        head_vld_d = head_vld_q;
        head_a_d   = head_a_q;
        head_b_d   = head_b_q;
        head_pkt_d = head_pkt_q;
        tail_vld_d = tail_vld_q;
        tail_a_d   = tail_a_q;
        tail_b_d   = tail_b_q;
        tail_pkt_d = tail_pkt_q;
        if (flush) begin
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
        end else begin
            if (pop) begin
                head_vld_d = tail_vld_q;
                head_a_d   = tail_a_q;
                head_b_d   = tail_b_q;
                head_pkt_d = tail_pkt_q;
                tail_vld_d = 1'b0;
            end
            // A new entry fills the head if it is free after the drain, else the tail.
            if (push) begin
                if (!head_vld_d) begin
                    head_vld_d = 1'b1;
                    head_a_d   = dec_op_a;
                    head_b_d   = dec_op_b;
                    head_pkt_d = dec_pkt;
                end else begin
                    tail_vld_d = 1'b1;
                    tail_a_d   = dec_op_a;
                    tail_b_d   = dec_op_b;
                    tail_pkt_d = dec_pkt;
                end
            end
        end
        in_ready_d = !(head_vld_d && tail_vld_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld_q <= 1'b0;
            head_a_q   <= '0;
            head_b_q   <= '0;
            head_pkt_q <= '0;
            tail_vld_q <= 1'b0;
            tail_a_q   <= '0;
            tail_b_q   <= '0;
            tail_pkt_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            head_vld_q <= head_vld_d;
            head_a_q   <= head_a_d;
            head_b_q   <= head_b_d;
            head_pkt_q <= head_pkt_d;
            tail_vld_q <= tail_vld_d;
            tail_a_q   <= tail_a_d;
            tail_b_q   <= tail_b_d;
            tail_pkt_q <= tail_pkt_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    assign in_ready = !rst && (!head_vld_q || out_ready);
    assign push     = in_valid && in_ready;

    always_comb begin
        head_vld_d = head_vld_q;
        head_a_d   = head_a_q;
        head_b_d   = head_b_q;
        head_pkt_d = head_pkt_q;
        if (flush) begin
            head_vld_d = 1'b0;
        end else if (push) begin
            head_vld_d = 1'b1;
            head_a_d   = dec_op_a;
            head_b_d   = dec_op_b;
            head_pkt_d = dec_pkt;
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld_q <= 1'b0;
            head_a_q   <= '0;
            head_b_q   <= '0;
            head_pkt_q <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_a_q   <= head_a_d;
            head_b_q   <= head_b_d;
            head_pkt_q <= head_pkt_d;
        end
    end
`endif

    assign out_valid = head_vld_q;
    assign op_a      = head_a_q;
    assign op_b      = head_b_q;
    assign alu_ctrl  = head_pkt_q.alu_ctrl;
    assign rd        = head_pkt_q.rd;
    assign illegal   = head_pkt_q.illegal;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and PC.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  decode-side instruction valid.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  WIDTH  instruction address.
REQ-008 rs1_data, rs2_data  input  WIDTH each  forwarded register operands.
REQ-009 flush  input  1  discard all held entries (branch redirect).
REQ-010 out_valid  output  1  issue packet valid toward the ALU stage.
REQ-011 out_ready  input  1  ALU stage accepts packet.
REQ-012 op_a, op_b  output  WIDTH each  ALU operands.
REQ-013 alu_ctrl  output  4  ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SRL, 0111 SLL, 1000 SRA, 1001 SLTU.
REQ-014 rd  output  5  destination register (instr[11:7]).
REQ-015 illegal  output  1  packet holds an undecodable instruction.

Function
REQ-016 Transfer in on in_valid&&in_ready; out on out_valid&&out_ready; latency one cycle from accept to out_valid.
REQ-017 Outputs SHALL stay stable while out_valid&&!out_ready.
REQ-018 OP (0110011): op_a=rs1, op_b=rs2; funct3/funct7[5] map 000/0 ADD, 000/1 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0 SRL, 101/1 SRA, 110 OR, 111 AND.
REQ-019 OP-IMM (0010011): op_a=rs1, op_b=sign-extended I-imm; same funct3 map, SUB never produced; shifts use imm[4:0], funct7[5] selects SRA.
REQ-020 LUI: op_a=0, op_b=U-imm, ADD; AUIPC: op_a=pc, op_b=U-imm, ADD.
REQ-021 LOAD/JALR: op_a=rs1, op_b=I-imm, ADD; STORE: op_a=rs1, op_b=S-imm, ADD; JAL: op_a=pc, op_b=4, ADD.
REQ-022 BRANCH: op_a=rs1, op_b=rs2; BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; funct3 010/011 illegal.
REQ-023 Any other opcode, or reserved funct7 on OP: illegal=1, alu_ctrl=0000, op_a=op_b=0, packet still issued.
REQ-024 Immediates sign-extended from bit 31 to WIDTH.
REQ-025 flush: all held entries dropped, out_valid=0 next cycle; flush wins over a same-cycle accept (accepted instruction discarded).
REQ-026 Simultaneous accept and drain with one entry held: throughput one packet per cycle, no bubble.

Reset
REQ-027 While rst high: out_valid=0, in_ready=0, op_a=op_b=0, alu_ctrl=0000, rd=0, illegal=0, all skid entries empty.
REQ-028 in_ready SHALL be 1 on the first rising edge after rst deasserts; reset mid-transfer drops all packets.

Configuration
REQ-029 Macro ALU_ISSUE_SKID_EN defined: two-entry skid buffer, in_ready is a flop output, deasserted only when both entries full.
REQ-030 Macro undefined: single output register, in_ready = !rst && (!out_valid || out_ready) combinationally.
REQ-031 Both variants SHALL present identical packet order and contents; only ready timing differs.

Structure
REQ-032 Package alu_pkg SHALL hold the 4-bit ALU op encodings, RV32I opcode constants and the issue-packet struct typedef.
REQ-033 Combinational decode SHALL live in sub-module alu_decode (instr, pc, rs1_data, rs2_data -> packet); alu_issue holds only registers and handshake.

Verification
REQ-034 instr=0x40208133 (sub x2,x1,x2), rs1=10, rs2=3 -> next cycle out_valid=1, alu_ctrl=0001, op_a=10, op_b=3, rd=2.
REQ-035 instr=0xFFF0A093 (slti x1,x1,-1) -> alu_ctrl=0101, op_b=0xFFFFFFFF; instr=0x4030D093 (srai x1,x1,3) -> alu_ctrl=1000, op_b[4:0]=3.
REQ-036 out_ready held 0 for 5 cycles with in_valid=1 -> outputs unchanged; with skid, in_ready=0 after 2 accepts; release -> both packets in order, no loss.
REQ-037 flush in same cycle as accept of AUIPC -> out_valid=0 next cycle, no packet emitted.
REQ-038 instr=0x0000007F -> illegal=1, alu_ctrl=0000, op_a=op_b=0; rst asserted mid-stall -> out_valid=0 immediately, in_ready=1 one edge after release.
